nn_trainer: RTL
===============

# nn_trainer

Backward (training) path for the two-input single-neuron network: iterates over the four-row truth table, runs the neuron forward with a piecewise-linear sigmoid, computes the output error and updates `w0`, `w1` and `bias` by a shifted-error delta rule. Its final weight and bias outputs drive the weight and bias inputs of the forward gate (AND, OR, NAND, ...). Training repeats in epochs until every row's error is within tolerance or an epoch limit is reached.

## Interface
- `LR_SHIFT`, 2: learning-rate right-shift applied to error.
- `TOL`, 16: max |error| (Q0.8 units) for a row to count as correct.
- `MAX_EPOCHS`, 64: epoch limit, 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin training; sampled in IDLE only.
- `target` in 4: desired output per row; bit index = {x1,x0}.
- `w0_init`, `w1_init`, `bias_init` in 8 each: signed initial values, latched on `start`.
- `w0`, `w1`, `bias` out 8 each: signed current weights; reset 0.
- `busy` out 1: high from the cycle after accepted `start` through the last CHK; reset 0.
- `done` out 1: one-cycle pulse after training ends; reset 0.
- `converged` out 1: set with `done` when the final epoch had all rows within TOL; cleared on `start`; reset 0.
- `epoch` out 8: completed-epoch count; cleared on `start`; reset 0.

## Operation
- States: IDLE, FWD, ACT, UPD, CHK, FIN.
- IDLE: on `start`=1, latch init values into `w0`/`w1`/`bias`, row=0, clear `epoch`/`converged`, set all_ok=1, go FWD.
- FWD: x0=row[0], x1=row[1]; register z = x0·w0 + x1·w1 + bias, signed 16-bit, sign-extended.
- ACT: y = clamp(128 + 16·z, 0, 255) (Q0.8 unsigned); t = target[row] ? 255 : 0; e = t − y, signed 10-bit, registered. If |e| > TOL, clear all_ok.
- UPD: delta = e >>> LR_SHIFT (arithmetic, floor). For each weight with input 1, and always for bias: new = clamp(old + delta, −128, 127). Weights with input 0 are unchanged. Then row+1. Go FWD if row≠3, else CHK.
- CHK: epoch+1. If all_ok or epoch+1 = MAX_EPOCHS, go FIN; otherwise all_ok=1, row=0, go FWD.
- FIN: pulse `done`, set `converged`=all_ok, drop `busy`, go IDLE.
- Weights hold their values in IDLE, and remain readable after `done`.
- `start` while not in IDLE is ignored. `target` and init inputs are only sampled in IDLE.

## Timing
- Per row: 3 cycles (FWD, ACT, UPD). Per epoch: 13 cycles (12 + CHK).
- Latency from `start` to `done`: 13·N + 2 cycles, where N = number of epochs run.
- Weight updates become visible on outputs the cycle after UPD.
- `rst` at any cycle: state IDLE, all outputs 0 on the next edge. This also aborts training in progress with no `done` pulse.
- `rst` and `start` in the same cycle: reset wins.

## Configuration
- `NN_TRAINER_SIGMOID_DERIV_EN` defined: ACT also registers d = (y·(255−y)) >> 6, range 0..254. UPD uses delta = (e·d) >>> (LR_SHIFT+8), which is true sigmoid-gradient scaling. A saturated wrong output then learns slowly or not at all.
- Undefined: delta = e >>> LR_SHIFT (perceptron-style), and there is no multiplier in UPD.

## Test plan
- Init w0=20, w1=20, bias=−30, target=4'b1000 → every e=0, weights unchanged, `done` 15 cycles after start, `converged`=1, `epoch`=1.
- Init all 0, target=4'b1000, LR_SHIFT=2, macro off → after row 0 UPD bias=−32, w0=w1=0; row 1 gives z=−32, y=0, e=0. With macro on, row 0 still gives bias=−32.
- Init w0=w1=bias=127, target=4'b0000, LR_SHIFT=0 → row 0 e=−255, bias saturates to −128 (not wrapped); w0 and w1 unchanged.
- target=4'b0110 (XOR), MAX_EPOCHS=4 → `done` exactly 54 cycles after start, `converged`=0, `epoch`=4.
- Assert `rst` during epoch 2 → next cycle all outputs 0, no `done`. A new `start` then runs normally from init values.
- `start` pulsed while busy, with changed `target` → ignored; result matches the original target.

Source files
------------

// File: rtl/nn_trainer.sv
// nn_trainer: delta-rule trainer for a two-input, single-neuron network.
// It walks the 4-row truth table per epoch and trains w0/w1/bias until
// every row is within TOL, or until MAX_EPOCHS epochs have run.
//
// Ports:
//   i_clk, i_rst (sync, active-high), i_start, i_target[3:0] (bit = {x1,x0}),
//   i_w0_init/i_w1_init/i_bias_init (signed 8b),
//   o_w0/o_w1/o_bias (signed 8b), o_busy, o_done (pulse), o_converged, o_epoch[7:0].
//
// Optional feature: NN_TRAINER_SIGMOID_DERIV_EN scales the error by the
// sigmoid slope y*(255-y)/64 instead of a plain shift.
module nn_trainer #(
    parameter int LR_SHIFT   = 2,
    parameter int TOL        = 16,
    parameter int MAX_EPOCHS = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [3:0]        i_target,
    input  logic signed [7:0] i_w0_init,
    input  logic signed [7:0] i_w1_init,
    input  logic signed [7:0] i_bias_init,
    output logic signed [7:0] o_w0,
    output logic signed [7:0] o_w1,
    output logic signed [7:0] o_bias,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_converged,
    output logic [7:0]        o_epoch
);

    typedef enum logic [2:0] {
        S_IDLE, S_FWD, S_ACT, S_UPD, S_CHK, S_FIN
    } state_t;

    state_t             r_state;
    logic [1:0]         r_row;
    logic [3:0]         r_target;
    logic               r_all_ok;
    logic signed [15:0] r_z;
    logic signed [9:0]  r_e;

    logic signed [15:0] w_z;
    logic signed [20:0] w_pre;
    logic [7:0]         w_y;
    logic signed [9:0]  w_t;
    logic signed [9:0]  w_e;
    logic [9:0]         w_abs_e;
    logic signed [10:0] w_delta;

    // Forward sum: inputs are 0/1, so multiplies reduce to selects.
    assign w_z = (r_row[0] ? 16'(o_w0) : 16'sd0)
               + (r_row[1] ? 16'(o_w1) : 16'sd0)
               + 16'(o_bias);

    // Piecewise-linear sigmoid: 128 + 16*z, clamped to Q0.8.
    assign w_pre = 21'sd128 + (21'(r_z) <<< 4);

    always_comb begin
        w_y = 8'd0;
        if (w_pre < 21'sd0)
            w_y = 8'd0;
        else if (w_pre > 21'sd255)
            w_y = 8'd255;
        else
            w_y = 8'(w_pre);
    end

    assign w_t     = r_target[r_row] ? 10'sd255 : 10'sd0;
    assign w_e     = w_t - $signed({2'b00, w_y});
    assign w_abs_e = w_e[9] ? 10'(-w_e) : 10'(w_e);

`ifdef NN_TRAINER_SIGMOID_DERIV_EN
    logic [7:0]         r_d;
    logic [13:0]        w_prod;
    logic [7:0]         w_d;
    logic signed [18:0] w_ed;

    // y*(255-y) peaks at 16256, so 14 bits hold it exactly.
    assign w_prod  = {6'd0, w_y} * {6'd0, 8'd255 - w_y};
    assign w_d     = 8'(w_prod >> 6);
    assign w_ed    = 19'(r_e) * $signed({11'd0, r_d});
    assign w_delta = 11'(w_ed >>> (LR_SHIFT + 8));
`else
    logic signed [10:0] w_ext;

    assign w_ext   = 11'(r_e);
    assign w_delta = w_ext >>> LR_SHIFT;
`endif

    function automatic logic signed [7:0] sat_add(
        input logic signed [7:0]  a,
        input logic signed [10:0] d
    );
        logic signed [11:0] s;
        s = 12'(a) + 12'(d);
        if (s > 12'sd127)
            return 8'sd127;
        else if (s < -12'sd128)
            return -8'sd128;
        else
            return 8'(s);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_row       <= 2'd0;
            r_target    <= 4'd0;
            r_all_ok    <= 1'b0;
            r_z         <= 16'sd0;
            r_e         <= 10'sd0;
            o_w0        <= 8'sd0;
            o_w1        <= 8'sd0;
            o_bias      <= 8'sd0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_converged <= 1'b0;
            o_epoch     <= 8'd0;
`ifdef NN_TRAINER_SIGMOID_DERIV_EN
            r_d         <= 8'd0;
`endif
        end else begin
            o_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        o_w0        <= i_w0_init;
                        o_w1        <= i_w1_init;
                        o_bias      <= i_bias_init;
                        r_target    <= i_target;
                        r_row       <= 2'd0;
                        o_epoch     <= 8'd0;
                        o_converged <= 1'b0;
                        r_all_ok    <= 1'b1;
                        o_busy      <= 1'b1;
                        r_state     <= S_FWD;
                    end
                end
                S_FWD: begin
                    r_z     <= w_z;
                    r_state <= S_ACT;
                end
                S_ACT: begin
                    r_e <= w_e;
`ifdef NN_TRAINER_SIGMOID_DERIV_EN
                    r_d <= w_d;
`endif
                    if (w_abs_e > 10'(TOL))
                        r_all_ok <= 1'b0;
                    r_state <= S_UPD;
                end
                S_UPD: begin
                    o_bias <= sat_add(o_bias, w_delta);
                    if (r_row[0])
                        o_w0 <= sat_add(o_w0, w_delta);
                    if (r_row[1])
                        o_w1 <= sat_add(o_w1, w_delta);
                    r_row   <= r_row + 2'd1;
                    r_state <= (r_row == 2'd3) ? S_CHK : S_FWD;
                end
                S_CHK: begin
                    o_epoch <= o_epoch + 8'd1;
                    if (r_all_ok || (o_epoch + 8'd1 == 8'(MAX_EPOCHS))) begin
                        o_busy  <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        r_all_ok <= 1'b1;
                        r_row    <= 2'd0;
                        r_state  <= S_FWD;
                    end
                end
                S_FIN: begin
                    o_done      <= 1'b1;
                    o_converged <= r_all_ok;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
